// File: rtl/ram_scan_reader_pkg.sv
// ram_scan_pkg: definitions shared by the RAM scan reader and the RAM wrapper.
//   state_t     - scan controller states; IDLE encodes as zero so that a reset
//                 controller reads back as all-zero on the debug port.
//   *_DEF       - default geometry and read latency of the 32x4 registered RAM.
package ram_scan_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 4;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        CAPT  = 3'd3,
        HOLD  = 3'd4,
        WRITE = 3'd5
    } state_t;

endpackage

// File: rtl/ram_scan_reader_tick_prescaler.sv
// tick_prescaler: free-running divider that produces one tick every TICK_DIV
// enabled cycles.
//   clk, resetn - clock, asynchronous active-low reset
//   clr         - synchronous clear, wins over en (counter restarts at 0)
//   en          - count enable
//   tick        - high for the one cycle in which the count is TICK_DIV-1
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ram_scan_reader.sv
// ram_scan_reader: read-side controller for the 32x4 registered-input RAM.
// Sweeps addresses 0..2**ADDR_W-1, fetches each word and presents it on
// disp_*. Scanning advances on a prescaler tick (auto) or on step pulses
// (single). The controller owns the RAM port; external writes are slotted in
// only while idle or holding a displayed word, so they never split a read.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   start, stop, step    1-cycle control pulses
//   single               1 = single-step, 0 = auto advance every TICK_DIV
//   wr_req/wr_addr/      write request; addr/data stable while wr_req is high
//   wr_data/wr_ack
//   ram_addr/ram_din/    RAM port (registered outputs)
//   ram_we/ram_dout
//   disp_addr/disp_data/ displayed word and its valid flag
//   disp_valid
//   busy                 1 in every state except IDLE
//   wrap                 1-cycle pulse when the scan address rolls over to 0
//   dbg_state            current controller state
//
// Write handshake: the requester raises wr_req with wr_addr/wr_data stable and
// holds them until it sees wr_ack. wr_ack is high for exactly the one cycle in
// which ram_we drives the write, so the requester may drop wr_req on the cycle
// it samples wr_ack high.
module ram_scan_reader
    import ram_scan_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TICK_DIV = 50_000_000,
    parameter int RD_LAT   = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic              single,
    input  logic              step,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              busy,
    output logic              wrap,
    output state_t            dbg_state
);

    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] scan_q, scan_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              stop_pend_q, stop_pend_d;   // stop seen mid-fetch
    logic              single_q, single_d;         // mode sampled at HOLD entry
    logic              ret_hold_q, ret_hold_d;     // WRITE was entered from HOLD
    logic              reread_q, reread_d;         // WRITE hit the displayed word

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              ram_we_q, ram_we_d;
    logic              wr_ack_q, wr_ack_d;
    logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic              disp_valid_q, disp_valid_d;
    logic              busy_q;
    logic              wrap_q, wrap_d;

    logic tick;
    logic presc_clr;
    logic presc_en;
    logic advance;

    // Prescaler is held clear outside HOLD, so every HOLD entry restarts it.
    assign presc_clr = (state_q != HOLD);
    assign presc_en  = (state_q == HOLD) && !single_q;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk    (clk),
        .resetn (resetn),
        .clr    (presc_clr),
        .en     (presc_en),
        .tick   (tick)
    );

    // A step coinciding with a tick is one advance; tick is never high in
    // single mode and step is ignored in auto mode.
    assign advance = tick || (single_q && step);

    always_comb begin
        state_d      = state_q;
        scan_d       = scan_q;
        wait_d       = wait_q;
        stop_pend_d  = stop_pend_q;
        single_d     = single_q;
        ret_hold_d   = ret_hold_q;
        reread_d     = reread_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        ram_we_d     = 1'b0;
        wr_ack_d     = 1'b0;
        disp_addr_d  = disp_addr_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        wrap_d       = 1'b0;

        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    state_d    = ADDR;
                    scan_d     = '0;
                    ram_addr_d = '0;
                end else if (wr_req) begin
                    state_d    = WRITE;
                    ram_addr_d = wr_addr;
                    ram_din_d  = wr_data;
                    ram_we_d   = 1'b1;
                    wr_ack_d   = 1'b1;
                    ret_hold_d = 1'b0;
                    reread_d   = 1'b0;
                end
            end

            ADDR: begin
                if (stop) stop_pend_d = 1'b1;
                state_d = WAIT;
                wait_d  = '0;
            end

            WAIT: begin
                if (stop) stop_pend_d = 1'b1;
                if (wait_q == WAIT_LAST) begin
                    state_d = CAPT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            CAPT: begin
                if (stop) stop_pend_d = 1'b1;
                disp_data_d  = ram_dout;
                disp_addr_d  = scan_q;
                disp_valid_d = 1'b1;
                single_d     = single;
                state_d      = HOLD;
            end

            HOLD: begin
                if (stop || stop_pend_q) begin
                    state_d     = IDLE;
                    stop_pend_d = 1'b0;
                end else if (wr_req) begin
                    state_d    = WRITE;
                    ram_addr_d = wr_addr;
                    ram_din_d  = wr_data;
                    ram_we_d   = 1'b1;
                    wr_ack_d   = 1'b1;
                    ret_hold_d = 1'b1;
                    reread_d   = (wr_addr == disp_addr_q);
                end else if (advance) begin
                    state_d    = ADDR;
                    scan_d     = scan_q + 1'b1;
                    ram_addr_d = scan_q + 1'b1;
                    wrap_d     = &scan_q;
                end
            end

            WRITE: begin
                if (stop && ret_hold_q) stop_pend_d = 1'b1;
                if (reread_q) begin
                    // The displayed word was overwritten: fetch it again.
                    state_d    = ADDR;
                    ram_addr_d = scan_q;
                end else if (ret_hold_q) begin
                    state_d  = HOLD;
                    single_d = single;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            scan_q       <= '0;
            wait_q       <= '0;
            stop_pend_q  <= 1'b0;
            single_q     <= 1'b0;
            ret_hold_q   <= 1'b0;
            reread_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ram_we_q     <= 1'b0;
            wr_ack_q     <= 1'b0;
            disp_addr_q  <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            scan_q       <= scan_d;
            wait_q       <= wait_d;
            stop_pend_q  <= stop_pend_d;
            single_q     <= single_d;
            ret_hold_q   <= ret_hold_d;
            reread_q     <= reread_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_we_q     <= ram_we_d;
            wr_ack_q     <= wr_ack_d;
            disp_addr_q  <= disp_addr_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            busy_q       <= (state_d != IDLE);
            wrap_q       <= wrap_d;
        end
    end

    assign wr_ack     = wr_ack_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign ram_we     = ram_we_q;
    assign disp_addr  = disp_addr_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign busy       = busy_q;
    assign wrap       = wrap_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Bench for ram_scan_reader with a 32x4 registered-input RAM model and
// TICK_DIV=4. Expected words come from a golden copy of the memory contents
// that the bench updates itself whenever it issues a write.
module tb_ram_scan_reader;
    import ram_scan_pkg::*;

    localparam int AW     = 5;
    localparam int DW     = 4;
    localparam int TD     = 4;
    localparam int RL     = 1;
    localparam int DEPTH  = 1 << AW;
    localparam int LAT    = RL + 2;        // ADDR entry to displayed word
    localparam int PERIOD = TD + RL + 2;   // capture to capture in auto mode

    // ---------------- clock / reset / DUT ----------------
    logic          clk     = 1'b0;
    logic          resetn  = 1'b1;
    logic          start   = 1'b0;
    logic          stop    = 1'b0;
    logic          single  = 1'b0;
    logic          step    = 1'b0;
    logic          wr_req  = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          busy;
    logic          wrap;
    state_t        dbg_state;

    always #5 clk = ~clk;

    ram_scan_reader #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .TICK_DIV (TD),
        .RD_LAT   (RL)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .stop       (stop),
        .single     (single),
        .step       (step),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .busy       (busy),
        .wrap       (wrap),
        .dbg_state  (dbg_state)
    );

    // ---------------- RAM model: registered addr/data/we ----------------
    logic [DW-1:0] mem      [DEPTH];
    logic [DW-1:0] init_mem [DEPTH];
    logic [AW-1:0] mem_addr_q = '0;
    logic          load = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_mem[i];
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        mem_addr_q <= ram_addr;
    end
    assign ram_dout = mem[mem_addr_q];

    // ---------------- scoreboard ----------------
    logic [DW-1:0]    ref_mem [DEPTH];
    logic [AW+DW-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    // ---------------- driver tasks ----------------
    task automatic preload(input bit rand_fill);
        for (int i = 0; i < DEPTH; i++) begin
            init_mem[i] = rand_fill ? DW'($urandom_range(0, 15)) : DW'(i & 15);
            ref_mem[i]  = init_mem[i];
        end
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1; @(negedge clk); step = 1'b0;
    endtask

    // Waits for the next displayed-word update; reports cycles waited and
    // whether a wrap pulse was seen on the way.
    task automatic wait_capture(input int budget, output int cyc,
                                output bit seen_wrap, output bit ok);
        state_t prev;
        prev = dbg_state; cyc = 0; seen_wrap = 1'b0; ok = 1'b0;
        while (!ok && cyc < budget) begin
            @(negedge clk); cyc++;
            if (wrap) seen_wrap = 1'b1;
            if (dbg_state == HOLD && prev == CAPT) ok = 1'b1;
            prev = dbg_state;
        end
    endtask

    // Issues one write; counts acks and ram_we cycles, including one cycle
    // after the request is dropped, and flags a wrong address/data on the port.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int acks, output int wes, output bit port_ok);
        int  cyc;
        bit  done;
        cyc = 0; done = 1'b0; acks = 0; wes = 0; port_ok = 1'b1;
        wr_addr = a; wr_data = d; wr_req = 1'b1;
        while (!done && cyc < 20) begin
            @(negedge clk); cyc++;
            if (ram_we) begin
                wes++;
                if (ram_addr !== a || ram_din !== d) port_ok = 1'b0;
            end
            if (wr_ack) begin acks++; done = 1'b1; end
        end
        wr_req = 1'b0;
        @(negedge clk);
        if (ram_we) wes++;
        if (wr_ack) acks++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3 resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ram_addr, ram_din, ram_we, wr_ack, disp_addr, disp_data,
             disp_valid, busy, wrap} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%0d din=%0h we=%b ack=%b disp=(%0d,%0h) v=%b busy=%b wrap=%b, expected all 0",
                     ram_addr, ram_din, ram_we, wr_ack, disp_addr, disp_data, disp_valid, busy, wrap);
        end
        n_checks++;
        if (dbg_state !== IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_auto_scan();
        int cyc; bit sw; bit ok;
        logic [AW-1:0] ea;
        preload(1'b0);
        single = 1'b0;
        pulse_start();
        wait_capture(20, cyc, sw, ok);
        n_checks++;
        if (!ok || cyc != LAT) begin
            n_fail++; $display("FAIL auto_first_latency: got ok=%b cycles=%0d expected %0d", ok, cyc, LAT);
        end
        n_checks++;
        if ({disp_valid, disp_addr, disp_data} !== {1'b1, AW'(0), ref_mem[0]}) begin
            n_fail++; $display("FAIL auto_first_word: got v=%b (%0d,%0h) expected v=1 (0,%0h)",
                               disp_valid, disp_addr, disp_data, ref_mem[0]);
        end
        for (int k = 1; k <= DEPTH; k++) begin
            ea = AW'(k % DEPTH);
            wait_capture(30, cyc, sw, ok);
            n_checks++;
            if (!ok || cyc != PERIOD) begin
                n_fail++; $display("FAIL auto_period[%0d]: got ok=%b cycles=%0d expected %0d", k, ok, cyc, PERIOD);
            end
            n_checks++;
            if ({disp_addr, disp_data} !== {ea, ref_mem[ea]}) begin
                n_fail++; $display("FAIL auto_word[%0d]: got (%0d,%0h) expected (%0d,%0h)",
                                   k, disp_addr, disp_data, ea, ref_mem[ea]);
            end
            n_checks++;
            if (sw !== (ea == 0)) begin
                n_fail++; $display("FAIL auto_wrap[%0d]: got %b expected %b", k, sw, (ea == 0));
            end
        end
        pulse_stop();
        @(negedge clk);
        n_checks++;
        if ({busy, disp_valid, disp_addr} !== {1'b0, 1'b1, AW'(0)}) begin
            n_fail++; $display("FAIL auto_stop: got busy=%b v=%b addr=%0d expected busy=0 v=1 addr=0",
                               busy, disp_valid, disp_addr);
        end
    endtask

    task automatic test_single_step();
        int cyc; bit sw; bit ok;
        preload(1'b1);
        single = 1'b1;
        pulse_start();
        wait_capture(20, cyc, sw, ok);
        n_checks++;
        if (!ok || {disp_addr, disp_data} !== {AW'(0), ref_mem[0]}) begin
            n_fail++; $display("FAIL single_first: got ok=%b (%0d,%0h) expected (0,%0h)",
                               ok, disp_addr, disp_data, ref_mem[0]);
        end
        repeat (3 * TD) @(negedge clk);
        n_checks++;
        if (dbg_state !== HOLD || disp_addr !== AW'(0)) begin
            n_fail++; $display("FAIL single_no_advance: got state=%0d addr=%0d expected state=%0d addr=0",
                               dbg_state, disp_addr, HOLD);
        end
        for (int s = 1; s <= 3; s++) begin
            pulse_step();
            wait_capture(20, cyc, sw, ok);
            n_checks++;
            if (!ok || cyc != LAT || {disp_addr, disp_data} !== {AW'(s), ref_mem[s]}) begin
                n_fail++; $display("FAIL single_step[%0d]: got ok=%b cycles=%0d (%0d,%0h) expected cycles=%0d (%0d,%0h)",
                                   s, ok, cyc, disp_addr, disp_data, LAT, s, ref_mem[s]);
            end
        end
        pulse_stop();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL single_stop: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_write_reread();
        int cyc; bit sw; bit ok; int acks; int wes; bit pok;
        logic [AW-1:0] oa;
        logic [DW-1:0] od;
        preload(1'b1);
        single = 1'b1;
        pulse_start();
        wait_capture(20, cyc, sw, ok);
        for (int s = 1; s <= 5; s++) begin
            pulse_step();
            wait_capture(20, cyc, sw, ok);
        end
        n_checks++;
        if (disp_addr !== AW'(5)) begin
            n_fail++; $display("FAIL wr_setup_addr: got %0d expected 5", disp_addr);
        end
        do_write(AW'(5), DW'(4'hA), acks, wes, pok);
        ref_mem[5] = DW'(4'hA);
        n_checks++;
        if (acks != 1 || wes != 1 || !pok) begin
            n_fail++; $display("FAIL wr_handshake: got acks=%0d we_cycles=%0d port_ok=%b expected 1 1 1", acks, wes, pok);
        end
        wait_capture(20, cyc, sw, ok);
        n_checks++;
        if (!ok || {disp_addr, disp_data} !== {AW'(5), ref_mem[5]}) begin
            n_fail++; $display("FAIL wr_reread: got ok=%b (%0d,%0h) expected (5,a)", ok, disp_addr, disp_data);
        end
        // write elsewhere: no re-read, display unchanged, memory updated
        oa = AW'($urandom_range(6, DEPTH - 1));
        od = DW'($urandom_range(0, 15));
        do_write(oa, od, acks, wes, pok);
        ref_mem[oa] = od;
        repeat (6) @(negedge clk);
        n_checks++;
        if (acks != 1 || wes != 1 || !pok || mem[oa] !== ref_mem[oa]) begin
            n_fail++; $display("FAIL wr_other: got acks=%0d we=%0d port_ok=%b mem=%0h expected 1 1 1 %0h",
                               acks, wes, pok, mem[oa], ref_mem[oa]);
        end
        n_checks++;
        if (dbg_state !== HOLD || {disp_addr, disp_data} !== {AW'(5), ref_mem[5]}) begin
            n_fail++; $display("FAIL wr_other_hold: got state=%0d (%0d,%0h) expected state=%0d (5,a)",
                               dbg_state, disp_addr, disp_data, HOLD);
        end
        pulse_stop();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || {disp_addr, disp_data} !== {AW'(5), ref_mem[5]}) begin
            n_fail++; $display("FAIL wr_stop: got busy=%b (%0d,%0h) expected busy=0 (5,a)", busy, disp_addr, disp_data);
        end
    endtask

    task automatic test_stop_and_write();
        int cyc; bit sw; bit ok; int acks;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        single = 1'b1;
        pulse_start();
        wait_capture(20, cyc, sw, ok);
        a = AW'($urandom_range(0, DEPTH - 1));
        d = DW'($urandom_range(0, 15));
        stop = 1'b1; wr_req = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        stop = 1'b0;
        n_checks++;
        if (dbg_state !== IDLE || busy !== 1'b0 || wr_ack !== 1'b0) begin
            n_fail++; $display("FAIL stopwr_idle_first: got state=%0d busy=%b ack=%b expected state=0 busy=0 ack=0",
                               dbg_state, busy, wr_ack);
        end
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wr_ack) begin acks++; wr_req = 1'b0; end
        end
        wr_req = 1'b0;
        ref_mem[a] = d;
        n_checks++;
        if (acks != 1 || busy !== 1'b0 || mem[a] !== ref_mem[a]) begin
            n_fail++; $display("FAIL stopwr_ack: got acks=%0d busy=%b mem=%0h expected 1 0 %0h", acks, busy, mem[a], ref_mem[a]);
        end
    endtask

    task automatic test_reset_mid_op();
        int cyc; bit sw; bit ok;
        single = 1'b0;
        pulse_start();
        @(negedge clk);
        n_checks++;
        if (dbg_state !== WAIT) begin
            n_fail++; $display("FAIL rst_pre_wait: got state=%0d expected %0d", dbg_state, WAIT);
        end
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({ram_addr, ram_din, ram_we, wr_ack, disp_addr, disp_data,
             disp_valid, busy, wrap} !== '0 || dbg_state !== IDLE) begin
            n_fail++; $display("FAIL rst_mid_wait: got addr=%0d v=%b busy=%b state=%0d expected all 0",
                               ram_addr, disp_valid, busy, dbg_state);
        end
        @(negedge clk); resetn = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_capture(20, cyc, sw, ok);
        n_checks++;
        if (!ok || cyc != LAT || {disp_addr, disp_data} !== {AW'(0), ref_mem[0]}) begin
            n_fail++; $display("FAIL rst_restart: got ok=%b cycles=%0d (%0d,%0h) expected cycles=%0d (0,%0h)",
                               ok, cyc, disp_addr, disp_data, LAT, ref_mem[0]);
        end
        pulse_stop();
        @(negedge clk);
        // reset while the write is on the RAM port
        wr_addr = AW'(3); wr_data = ~ref_mem[3]; wr_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ram_we !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_write: got ram_we=%b expected 1", ram_we);
        end
        resetn = 1'b0;
        #1;
        n_checks++;
        if (ram_we !== 1'b0 || wr_ack !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_write: got ram_we=%b ack=%b expected 0 0", ram_we, wr_ack);
        end
        wr_req = 1'b0;
        @(negedge clk); resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem[3] !== ref_mem[3]) begin
            n_fail++; $display("FAIL rst_write_dropped: got mem=%0h expected %0h", mem[3], ref_mem[3]);
        end
    endtask

    task automatic test_random_scan();
        int cyc; bit sw; bit ok; int acks; int wes; bit pok;
        logic [AW-1:0]    cur, nxt, wa;
        logic [DW-1:0]    wd;
        logic [AW+DW-1:0] exp_w;
        preload(1'b1);
        single = 1'b0;
        exp_q.delete();
        pulse_start();
        exp_q.push_back({AW'(0), ref_mem[0]});
        for (int it = 0; it < 40; it++) begin
            wait_capture(40, cyc, sw, ok);
            exp_w = exp_q.pop_front();
            n_checks++;
            if (!ok || {disp_addr, disp_data} !== exp_w) begin
                n_fail++; $display("FAIL rand_word[%0d]: got ok=%b (%0d,%0h) expected (%0d,%0h)",
                                   it, ok, disp_addr, disp_data, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
            end
            cur = exp_w[AW+DW-1:DW];
            nxt = cur + 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                wa = ($urandom_range(0, 1) == 1) ? cur : AW'($urandom_range(0, DEPTH - 1));
                wd = DW'($urandom_range(0, 15));
                do_write(wa, wd, acks, wes, pok);
                ref_mem[wa] = wd;
                n_checks++;
                if (acks != 1 || wes != 1 || !pok) begin
                    n_fail++; $display("FAIL rand_write[%0d]: got acks=%0d we=%0d port_ok=%b expected 1 1 1",
                                       it, acks, wes, pok);
                end
                if (wa == cur) nxt = cur;
            end
            exp_q.push_back({nxt, ref_mem[nxt]});
        end
        pulse_stop();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL rand_stop: got busy=%b expected 0", busy);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_auto_scan();
        test_single_step();
        test_write_reread();
        test_stop_and_write();
        test_reset_mid_op();
        test_random_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
